// File: rtl/pacman_pkg.sv
// Shared types for the tile/sprite RAM arbiter: owner tags, default widths and the RAM command word.
package pacman_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } owner_tag_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic                  we;
    logic [DATA_W_DEF-1:0] wdata;
  } ram_cmd_t;

endpackage

// File: rtl/tile_ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the port not served last.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // 1 = port 1 was served last, so port 0 wins the next tie
  logic last1_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = last1_q;
        gnt1 = !last1_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last1_q <= 1'b1;
    end else if (gnt0) begin
      last1_q <= 1'b0;
    end else if (gnt1) begin
      last1_q <= 1'b1;
    end
  end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Single-port tile RAM sharing: video reads at strict priority, game/CPU round-robin on the rest.
module tile_ram_arbiter
  import pacman_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 64
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              gm_req,
  input  logic [ADDR_W-1:0] gm_addr,
  input  logic [DATA_W-1:0] gm_wdata,
  output logic              gm_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              starve_clr,
  output logic              starve_flag,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic       gm_gnt;
  logic       cpu_gnt;
  ram_cmd_t   cmd_d;
  ram_cmd_t   cmd_q;
  owner_tag_e tag_d;
  owner_tag_e tag1_q;
  owner_tag_e tag2_q;
  logic       gm_ack_q;
  logic       cpu_ack_q;

  logic [DATA_W-1:0] vid_hold_q;
  logic [DATA_W-1:0] cpu_hold_q;

  logic [1:0]            wait_req;
  logic [1:0]            wait_gnt;
  logic [1:0][CNT_W-1:0] wait_d;
  logic [1:0][CNT_W-1:0] wait_q;
  logic                  starve_evt;
  logic                  starve_flag_q;

  rr_arb2 u_rr_arb2 (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .en    (!vid_req),
    .req0  (gm_req),
    .req1  (cpu_req),
    .gnt0  (gm_gnt),
    .gnt1  (cpu_gnt)
  );

  // Next command word; with no grant the address is held and the write strobe dropped.
  always_comb begin
    cmd_d    = cmd_q;
    cmd_d.we = 1'b0;
    tag_d    = TAG_NONE;
    if (vid_req) begin
      cmd_d.addr = vid_addr;
      tag_d      = TAG_VID;
    end else if (gm_gnt) begin
      cmd_d.addr  = gm_addr;
      cmd_d.we    = 1'b1;
      cmd_d.wdata = gm_wdata;
    end else if (cpu_gnt) begin
      cmd_d.addr  = cpu_addr;
      cmd_d.we    = cpu_we;
      cmd_d.wdata = cpu_wdata;
      if (!cpu_we) begin
        tag_d = TAG_CPU;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cmd_q     <= '0;
      tag1_q    <= TAG_NONE;
      tag2_q    <= TAG_NONE;
      gm_ack_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
    end else begin
      cmd_q     <= cmd_d;
      tag1_q    <= tag_d;
      tag2_q    <= tag1_q;
      gm_ack_q  <= gm_gnt;
      cpu_ack_q <= cpu_gnt;
    end
  end

  assign ram_addr  = cmd_q.addr;
  assign ram_we    = cmd_q.we;
  assign ram_wdata = cmd_q.wdata;
  assign gm_ack    = gm_ack_q;
  assign cpu_ack   = cpu_ack_q;

  // RAM data arrives with the second tag stage; the holding registers keep the last delivered word.
  assign vid_rvalid = (tag2_q == TAG_VID);
  assign cpu_rvalid = (tag2_q == TAG_CPU);
  assign vid_rdata  = vid_rvalid ? ram_rdata : vid_hold_q;
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_hold_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vid_hold_q <= '0;
      cpu_hold_q <= '0;
    end else begin
      if (vid_rvalid) begin
        vid_hold_q <= ram_rdata;
      end
      if (cpu_rvalid) begin
        cpu_hold_q <= ram_rdata;
      end
    end
  end

  assign wait_req = {cpu_req, gm_req};
  assign wait_gnt = {cpu_gnt, gm_gnt};

  // Counters track consecutive waiting cycles; only the transition onto the limit raises the flag.
  always_comb begin
    wait_d     = wait_q;
    starve_evt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!wait_req[i] || wait_gnt[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != CNT_MAX) begin
        wait_d[i] = wait_q[i] + CNT_W'(1);
      end
      if ((wait_d[i] == CNT_MAX) && (wait_q[i] != CNT_MAX)) begin
        starve_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wait_q        <= '0;
      starve_flag_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      if (starve_evt) begin
        starve_flag_q <= 1'b1;
      end else if (starve_clr) begin
        starve_flag_q <= 1'b0;
      end
    end
  end

  assign starve_flag = starve_flag_q;

endmodule
